// File: rtl/button_press_decoder.sv
// Classifies debounced button presses as short, long or double and pulses one event per gesture.
// Optional auto-repeat while long-held is enabled with `define BTN_AUTOREPEAT_EN.
module button_press_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clean_in,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    S_LOCKOUT,
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT_SECOND,
    S_SECOND_PRESSED
  } state_t;

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  if (LONG_CYCLES == 0 || GAP_CYCLES == 0 || REPEAT_CYCLES == 0 ||
      64'(LONG_CYCLES) > CNT_SPAN || 64'(GAP_CYCLES) > CNT_SPAN ||
      64'(REPEAT_CYCLES) > CNT_SPAN) begin : g_bad_params
    $error("button_press_decoder: zero period or CNT_W too narrow");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic [7:0]       cnt_q, cnt_d;

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      S_LOCKOUT: if (!clean_in) state_d = S_IDLE;
      S_IDLE:    if (clean_in) state_d = S_PRESSED;
      S_PRESSED: begin
        timer_d = timer_inc;
        if (!clean_in) begin
          state_d = S_WAIT_SECOND;
        end else if (timer_q == LONG_LAST) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      S_LONG_HELD: if (!clean_in) state_d = S_IDLE;
      S_WAIT_SECOND: begin
        timer_d = timer_inc;
        if (clean_in) begin
          state_d = S_SECOND_PRESSED;
        end else if (timer_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_SECOND_PRESSED: begin
        timer_d = timer_inc;
        if (!clean_in) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = S_LOCKOUT;
    endcase
    // Every state change restarts the timer, so no per-transition clears above.
    if (state_d != state_q) timer_d = '0;
    busy_d = (state_d != S_IDLE) && (state_d != S_LOCKOUT);
    cnt_d  = cnt_q + 8'(short_d | long_d | double_d);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;

  // Counter is zero whenever not long-held, so the first tick lands REPEAT_CYCLES after long_press.
  always_comb begin
    rep_d    = '0;
    repeat_d = 1'b0;
    if (state_q == S_LONG_HELD && clean_in) begin
      if (rep_q == REP_LAST) begin
        repeat_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign repeat_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOCKOUT;
      timer_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;
  assign event_count  = cnt_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder: stimulus queues expected pulses, a monitor pops them.
module tb_button_press_decoder;

  localparam int unsigned LONG = 100;
  localparam int unsigned GAP  = 40;
  localparam int unsigned REP  = 20;

  localparam logic [3:0] K_SHORT  = 4'b0001;
  localparam logic [3:0] K_LONG   = 4'b0010;
  localparam logic [3:0] K_DOUBLE = 4'b0100;
  localparam logic [3:0] K_REPEAT = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk, rst, clean_in;
  logic       short_press, long_press, double_press, repeat_pulse, busy;
  logic [7:0] event_count;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_count = '0;

  button_press_decoder #(
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clean_in    (clean_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy),
    .event_count (event_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of the scoreboard in kind, cycle and count.
  always @(negedge clk) begin
    logic [3:0] kind;
    exp_t e;
    kind = {repeat_pulse, double_press, long_press, short_press};
    if (kind != 4'b0000) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse kind=%b cyc=%0d count=%0d required=no pulse", kind, cyc, event_count);
      end else begin
        e = sb.pop_front();
        if (kind != e.kind || cyc != e.cyc || event_count != e.cnt) begin
          n_fail++;
          $display("FAIL pulse actual kind=%b cyc=%0d count=%0d required kind=%b cyc=%0d count=%0d",
                   kind, cyc, event_count, e.kind, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] k, input int c, input logic [7:0] n);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    sb.push_back(e);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_short"},  int'(short_press),  0);
    chk({name, "_long"},   int'(long_press),   0);
    chk({name, "_double"}, int'(double_press), 0);
    chk({name, "_repeat"}, int'(repeat_pulse), 0);
    chk({name, "_busy"},   int'(busy),         0);
    chk({name, "_count"},  int'(event_count),  0);
  endtask

  task automatic short_seq(input int hold);
    clean_in = 1'b1;
    tick(hold);
    clean_in = 1'b0;
    exp_count++;
    push(K_SHORT, cyc + GAP + 1, exp_count);
    tick(GAP + 5);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    clean_in = 1'b1;
    tick(3);
    chk_quiet("reset");

    // Button held through reset must be ignored.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("lockout_busy", int'(busy), 0);
    end
    clean_in = 1'b0;
    tick(60);
    chk("lockout_count", int'(event_count), 0);

    // Single short press.
    clean_in = 1'b1;
    tick(5);
    chk("pressed_busy", int'(busy), 1);
    tick(25);
    clean_in = 1'b0;
    exp_count++;
    push(K_SHORT, cyc + GAP + 1, exp_count);
    tick(GAP + 10);
    chk("short_busy_after", int'(busy), 0);
    chk("short_count", int'(event_count), 1);

    // Long press held 150 cycles.
    t = cyc;
    clean_in = 1'b1;
    exp_count++;
    push(K_LONG, t + LONG + 1, exp_count);
`ifdef BTN_AUTOREPEAT_EN
    push(K_REPEAT, t + LONG + 1 + REP, exp_count);
    push(K_REPEAT, t + LONG + 1 + 2 * REP, exp_count);
`endif
    tick(150);
    clean_in = 1'b0;
    tick(GAP + 20);
    chk("long_busy_after", int'(busy), 0);

    // Double press.
    clean_in = 1'b1;
    tick(20);
    clean_in = 1'b0;
    tick(10);
    clean_in = 1'b1;
    tick(20);
    clean_in = 1'b0;
    exp_count++;
    push(K_DOUBLE, cyc + 1, exp_count);
    tick(GAP + 20);
    chk("double_count", int'(event_count), 3);

    // Second press sampled on the timeout edge: press wins.
    clean_in = 1'b1;
    tick(5);
    clean_in = 1'b0;
    tick(GAP);
    clean_in = 1'b1;
    tick(5);
    clean_in = 1'b0;
    exp_count++;
    push(K_DOUBLE, cyc + 1, exp_count);
    tick(10);

    // Press one cycle after the timeout: short fires, new press starts fresh.
    clean_in = 1'b1;
    tick(5);
    clean_in = 1'b0;
    exp_count++;
    push(K_SHORT, cyc + GAP + 1, exp_count);
    tick(GAP + 1);
    clean_in = 1'b1;
    tick(5);
    clean_in = 1'b0;
    exp_count++;
    push(K_SHORT, cyc + GAP + 1, exp_count);
    tick(GAP + 5);
    chk("gap_count", int'(event_count), 6);

    // Reset while waiting for a second press discards the pending short.
    clean_in = 1'b1;
    tick(10);
    clean_in = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk_quiet("midreset");
    tick(2);
    rst = 1'b0;
    exp_count = '0;
    tick(GAP + 5);
    short_seq(10);
    chk("post_reset_count", int'(event_count), 1);

    // 256 short presses from zero wrap the counter back to zero.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_count = '0;
    tick(2);
    for (int i = 0; i < 256; i++) short_seq(3);
    chk("wrap_count", int'(event_count), 0);

    tick(10);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
